uart_frame_streamer: RTL

Sequences the UART transmitter to send one processed image frame from on-chip pixel RAM to the host. On a start pulse it emits a 2-byte sync header, then every pixel byte in address order, then raises a done pulse. It sits between the smoothing-kernel output buffer (synchronous-read RAM) and the `uart` block, driving its `data_in`/`wr_en` and pacing on `Tx_busy`.

---
 rtl/uart_frame_streamer_pkg.sv | 31 +++
 rtl/uart_frame_streamer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/uart_frame_streamer_pkg.sv
// ============================================================================
//  Module      : uart_frame_streamer_pkg
//  Description : Shared types and defaults for the UART frame streamer:
//                FSM state encoding and the sync header byte defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package uart_frame_streamer_pkg;

  // Streamer FSM states, explicit 4-bit encoding
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_HDR0    = 4'd1,
    S_HDR1    = 4'd2,
    S_RD      = 4'd3,
    S_LATCH   = 4'd4,
    S_SEND    = 4'd5,
    S_WAIT_HI = 4'd6,
    S_WAIT_LO = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  // Default sync header bytes sent ahead of every frame
  localparam logic [7:0] SYNC0_DEFAULT = 8'hAA;
  localparam logic [7:0] SYNC1_DEFAULT = 8'h55;

endpackage : uart_frame_streamer_pkg

`default_nettype wire

// File: rtl/uart_frame_streamer.sv
// ============================================================================
//  Module      : uart_frame_streamer
//  Description : Streams one image frame (2-byte sync header followed by every
//                pixel in address order) from a synchronous-read pixel RAM to
//                a UART transmitter, pacing each byte on the UART busy flag.
//                All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_frame_streamer
  import uart_frame_streamer_pkg::*;
#(
  parameter int         NUM_PIX = 16384,
  parameter int         ADDR_W  = 14,
  parameter logic [7:0] SYNC0   = SYNC0_DEFAULT,
  parameter logic [7:0] SYNC1   = SYNC1_DEFAULT
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic [7:0]        tx_data,
  output logic              tx_wr,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done
);

  // Address of the final pixel; the counter stops here rather than wrapping
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

  state_t              state_q, state_d;
  state_t              ret_q, ret_d;      // state to resume once the UART frees up
  logic                pix_q, pix_d;      // byte in flight is a pixel (not header)
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_rd_q, mem_rd_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_wr_q, tx_wr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Register the FSM, counter and all outputs
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ret_q      <= S_IDLE;
      pix_q      <= 1'b0;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_wr_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      pix_q      <= pix_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      tx_data_q  <= tx_data_d;
      tx_wr_q    <= tx_wr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next state, plus outputs decoded from the next state so they register
  // alongside it (Moore outputs with no input-to-output combinational path)
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    pix_d   = pix_q;
    cnt_d   = cnt_q;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_HDR0;
            cnt_d   = '0;
          end
        end
        S_HDR0: begin
          state_d = S_WAIT_HI;
          ret_d   = S_HDR1;
          pix_d   = 1'b0;
        end
        S_HDR1: begin
          state_d = S_WAIT_HI;
          ret_d   = S_RD;
          pix_d   = 1'b0;
        end
        S_RD:    state_d = S_LATCH;
        S_LATCH: state_d = S_SEND;
        S_SEND: begin
          state_d = S_WAIT_HI;
          pix_d   = 1'b1;
          ret_d   = (cnt_q == LAST_ADDR) ? S_DONE : S_RD;
        end
        S_WAIT_HI: begin
          if (tx_busy) state_d = S_WAIT_LO;
        end
        S_WAIT_LO: begin
          if (!tx_busy) begin
            state_d = ret_q;
            // The last pixel leaves the counter at LAST_ADDR so it never wraps
            if (pix_q && (ret_q != S_DONE)) cnt_d = cnt_q + ADDR_W'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    tx_wr_d    = (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_SEND);
    mem_rd_d   = (state_d == S_RD);
    mem_addr_d = (state_d == S_RD) ? cnt_d : mem_addr_q;
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);

    // tx_data only changes when a header byte is loaded or a pixel is latched
    tx_data_d = tx_data_q;
    if (state_d == S_HDR0) begin
      tx_data_d = SYNC0;
    end else if (state_d == S_HDR1) begin
      tx_data_d = SYNC1;
    end else if ((state_q == S_LATCH) && (state_d == S_SEND)) begin
      tx_data_d = mem_data;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_rd   = mem_rd_q;
  assign tx_data  = tx_data_q;
  assign tx_wr    = tx_wr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule : uart_frame_streamer

`default_nettype wire
